// File: rtl/ay8_pkg.sv
// Shared types for the AY8 front end: fetch FSM states, prefetch FIFO entry
// layout and a small program-counter helper.
package ay8_pkg;

    localparam int PC_W   = 8;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } fetch_state_e;

    // data sits in the upper byte so {bus, pc} concatenations map directly
    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic [PC_W-1:0]   pc;
    } fifo_entry_t;

    function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Decoder-side byte stream of the instruction fetcher: valid/ready handshake
// carrying the fetched byte and the address it came from.
interface instr_fetch_if;
    import ay8_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [BYTE_W-1:0] out_byte;
    logic [PC_W-1:0]   out_pc;

    modport master (
        output out_valid,
        output out_byte,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_byte,
        input  out_pc,
        output out_ready
    );

endinterface

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO holding {byte, pc} entries; flush empties it in one edge and
// takes priority over push and pop. Head is visible combinationally.
module ifetch_fifo
    import ay8_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  fifo_entry_t            push_data,
    input  logic                   pop,
    output fifo_entry_t            head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    fifo_entry_t      entry_q [DEPTH];
    logic [DEPTH-1:0] wr_sel;
    logic             full;
    logic             do_write;
    logic             do_read;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign do_write = push && !full && !flush;
    assign do_read  = pop && !empty && !flush;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = do_write && (wr_ptr_q == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_write) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_read) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_write, do_read})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Entries are cleared on reset so the head reads as zero until first written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    entry_q[i] <= push_data;
                end
            end
        end
    end

    assign head  = entry_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetcher: two-cycle ADDR/DATA reads on the shared uniBus feeding a
// prefetch FIFO. Optional byte counter perf_cnt when IFETCH_PERF_EN is defined.
module instr_fetch
    import ay8_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
    input  logic              CLK,
    input  logic              RST,
    inout  wire  [BYTE_W-1:0] uniBus,
    output logic              mem_req,
    output logic              mem_rd,
    input  logic              pc_load,
    input  logic [PC_W-1:0]   pc_new,
    instr_fetch_if.master     dec
`ifdef IFETCH_PERF_EN
    ,
    output logic [15:0]       perf_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic              discard_q, discard_d;

    logic              push;
    logic              pop;
    fifo_entry_t       push_entry;
    fifo_entry_t       head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;

    // A redirect outranks any transfer to the decoder in the same cycle.
    assign pop        = dec.out_valid && dec.out_ready && !pc_load;
    assign push_entry = {uniBus, fetch_pc_q};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                if (pc_load || (fifo_count < CNT_W'(DEPTH))) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                state_d = DATA;
                if (pc_load) begin
                    discard_d = 1'b1;
                end
            end
            DATA: begin
                discard_d = 1'b0;
                push      = !discard_q && !pc_load;
                // Room after this capture: no push, a concurrent pop, or spare slots.
                if (!push || pop || (fifo_count < CNT_W'(DEPTH - 1))) begin
                    state_d = ADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pc_load) begin
            fetch_pc_d = pc_new;
        end else if (push) begin
            fetch_pc_d = pc_next(fetch_pc_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RST),
        .flush     (pc_load),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign mem_req = (state_q == ADDR);
    assign mem_rd  = 1'b1;
    assign uniBus  = mem_req ? fetch_pc_q : 8'hzz;

    assign dec.out_valid = !fifo_empty;
    assign dec.out_byte  = head.data;
    assign dec.out_pc    = head.pc;

`ifdef IFETCH_PERF_EN
    logic [15:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (push && (perf_q != 16'hFFFF)) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            perf_q <= 16'h0000;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cnt = perf_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: cycle table for the reset fetch stream plus
// hand sequences for backpressure, redirects, wrap, mid-DATA reset and perf_cnt.
module tb_instr_fetch;

    logic       CLK = 1'b0;
    logic       RST;
    logic       pc_load;
    logic [7:0] pc_new;
    logic       pc_load_w;
    logic [7:0] pc_new_w;
    wire  [7:0] bus0;
    wire  [7:0] bus1;
    logic       mem_req0, mem_rd0, mem_req1, mem_rd1;
    logic [7:0] mem [256];
    logic       drv0_q, drv1_q;
    logic [7:0] a0_q, a1_q;
    int         n_tests = 0;
    int         n_fail  = 0;
`ifdef IFETCH_PERF_EN
    logic [15:0] perf0, perf1;
`endif

    instr_fetch_if dec0 ();
    instr_fetch_if dec1 ();

    always #5 CLK = ~CLK;

    instr_fetch #(.DEPTH(4), .RESET_PC(8'h00)) dut (
        .CLK(CLK), .RST(RST), .uniBus(bus0), .mem_req(mem_req0), .mem_rd(mem_rd0),
        .pc_load(pc_load), .pc_new(pc_new), .dec(dec0)
`ifdef IFETCH_PERF_EN
        , .perf_cnt(perf0)
`endif
    );

    instr_fetch #(.DEPTH(4), .RESET_PC(8'hFE)) dut_w (
        .CLK(CLK), .RST(RST), .uniBus(bus1), .mem_req(mem_req1), .mem_rd(mem_rd1),
        .pc_load(pc_load_w), .pc_new(pc_new_w), .dec(dec1)
`ifdef IFETCH_PERF_EN
        , .perf_cnt(perf1)
`endif
    );

    // Memory: latch the address in ADDR, drive data for the following cycle.
    always @(posedge CLK) begin
        drv0_q <= mem_req0 && RST;
        drv1_q <= mem_req1 && RST;
        a0_q   <= bus0;
        a1_q   <= bus1;
    end
    assign bus0 = drv0_q ? mem[a0_q] : 8'hzz;
    assign bus1 = drv1_q ? mem[a1_q] : 8'hzz;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %04h expected %04h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST     = 1'b0;
        pc_load = 1'b0;
        tick();
        tick();
        RST = 1'b1;
    endtask

    typedef struct {
        logic       rdy;
        logic       req;
        logic [7:0] bus;
        logic       vld;
        logic       cd;
        logic [7:0] byt;
        logic [7:0] pc;
    } vec_t;

    vec_t       tbl [11];
    logic [7:0] wb [3];
    logic [7:0] wp [3];
    int         n_addr;
    int         k;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(8'h10 + i);
        mem[8'hFE] = 8'hAA;
        mem[8'hFF] = 8'hBB;
        wb[0] = 8'hAA; wb[1] = 8'hBB; wb[2] = 8'h10;
        wp[0] = 8'hFE; wp[1] = 8'hFF; wp[2] = 8'h00;

        // rows are the state just after each edge following reset release
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00};
        tbl[1]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[3]  = '{1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 8'h10, 8'h00};
        tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[5]  = '{1'b1, 1'b1, 8'h02, 1'b1, 1'b1, 8'h11, 8'h01};
        tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[7]  = '{1'b1, 1'b1, 8'h03, 1'b1, 1'b1, 8'h12, 8'h02};
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[9]  = '{1'b1, 1'b1, 8'h04, 1'b1, 1'b1, 8'h13, 8'h03};
        tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};

        RST            = 1'b0;
        pc_load        = 1'b0;
        pc_new         = 8'h00;
        pc_load_w      = 1'b0;
        pc_new_w       = 8'h00;
        dec0.out_ready = 1'b1;
        dec1.out_ready = 1'b1;

        // Reset fetch stream
        do_reset();
        chk("reset_mem_rd", 16'(mem_rd0), 16'd1);
        chk("reset_mem_rd_w", 16'(mem_rd1), 16'd1);
        for (int i = 0; i < 11; i++) begin
            if (i > 0) tick();
            chk($sformatf("t%0d_req", i), 16'(mem_req0), 16'(tbl[i].req));
            chk($sformatf("t%0d_valid", i), 16'(dec0.out_valid), 16'(tbl[i].vld));
            if (tbl[i].req) chk($sformatf("t%0d_bus", i), 16'(bus0), 16'(tbl[i].bus));
            if (tbl[i].cd) begin
                chk($sformatf("t%0d_byte", i), 16'(dec0.out_byte), 16'(tbl[i].byt));
                chk($sformatf("t%0d_pc", i), 16'(dec0.out_pc), 16'(tbl[i].pc));
            end
            dec0.out_ready = tbl[i].rdy;
        end

        // Backpressure: four ADDR phases then idle with the head held
        dec0.out_ready = 1'b0;
        do_reset();
        n_addr = 0;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (mem_req0) n_addr++;
        end
        chk("bp_addr_phases", 16'(n_addr), 16'd4);
        chk("bp_req_idle", 16'(mem_req0), 16'd0);
        chk("bp_valid", 16'(dec0.out_valid), 16'd1);
        chk("bp_byte_held", 16'(dec0.out_byte), 16'h10);
        chk("bp_pc_held", 16'(dec0.out_pc), 16'h00);
        dec0.out_ready = 1'b1;
        tick();
        dec0.out_ready = 1'b0;
        chk("bp_pop_byte", 16'(dec0.out_byte), 16'h11);
        chk("bp_pop_pc", 16'(dec0.out_pc), 16'h01);
        chk("bp_pop_req", 16'(mem_req0), 16'd0);
        tick();
        chk("bp_resume_req", 16'(mem_req0), 16'd1);
        chk("bp_resume_bus", 16'(bus0), 16'h04);
        pc_load = 1'b1;
        pc_new  = 8'h80;
        tick();
        pc_load = 1'b0;
        chk("flush_valid", 16'(dec0.out_valid), 16'd0);
        tick();
        chk("flush_next_req", 16'(mem_req0), 16'd1);
        chk("flush_next_bus", 16'(bus0), 16'h80);

        // Redirect during DATA of pc 0
        dec0.out_ready = 1'b1;
        do_reset();
        tick();
        chk("rd_addr0_req", 16'(mem_req0), 16'd1);
        tick();
        chk("rd_data0_req", 16'(mem_req0), 16'd0);
        pc_load = 1'b1;
        pc_new  = 8'h02;
        tick();
        pc_load = 1'b0;
        chk("rd_valid0", 16'(dec0.out_valid), 16'd0);
        chk("rd_req", 16'(mem_req0), 16'd1);
        chk("rd_bus", 16'(bus0), 16'h02);
        tick();
        tick();
        chk("rd_b1_valid", 16'(dec0.out_valid), 16'd1);
        chk("rd_b1_byte", 16'(dec0.out_byte), 16'h12);
        chk("rd_b1_pc", 16'(dec0.out_pc), 16'h02);
        tick();
        tick();
        chk("rd_b2_valid", 16'(dec0.out_valid), 16'd1);
        chk("rd_b2_byte", 16'(dec0.out_byte), 16'h13);
        chk("rd_b2_pc", 16'(dec0.out_pc), 16'h03);

        // Redirect during ADDR: the started read completes but is dropped
        do_reset();
        tick();
        pc_load = 1'b1;
        pc_new  = 8'h40;
        tick();
        pc_load = 1'b0;
        chk("ra_data_req", 16'(mem_req0), 16'd0);
        chk("ra_valid0", 16'(dec0.out_valid), 16'd0);
        tick();
        chk("ra_req", 16'(mem_req0), 16'd1);
        chk("ra_bus", 16'(bus0), 16'h40);
        chk("ra_valid1", 16'(dec0.out_valid), 16'd0);
        tick();
        tick();
        chk("ra_valid2", 16'(dec0.out_valid), 16'd1);
        chk("ra_byte", 16'(dec0.out_byte), 16'h50);
        chk("ra_pc", 16'(dec0.out_pc), 16'h40);

        // Reset in the middle of DATA
        dec0.out_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 4; c++) tick();
        chk("rm_pre_valid", 16'(dec0.out_valid), 16'd1);
        RST = 1'b0;
        tick();
        RST = 1'b1;
        chk("rm_valid", 16'(dec0.out_valid), 16'd0);
        chk("rm_req", 16'(mem_req0), 16'd0);
        chk("rm_byte", 16'(dec0.out_byte), 16'h00);
        chk("rm_pc", 16'(dec0.out_pc), 16'h00);
        tick();
        chk("rm_restart_req", 16'(mem_req0), 16'd1);
        chk("rm_restart_bus", 16'(bus0), 16'h00);
        tick();
        tick();
        chk("rm_valid1", 16'(dec0.out_valid), 16'd1);
        chk("rm_byte1", 16'(dec0.out_byte), 16'h10);
        chk("rm_pc1", 16'(dec0.out_pc), 16'h00);

        // Wrap from RESET_PC = FE
        dec1.out_ready = 1'b1;
        do_reset();
        k = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (dec1.out_valid) begin
                if (k < 3) begin
                    chk($sformatf("wrap%0d_byte", k), 16'(dec1.out_byte), 16'(wb[k]));
                    chk($sformatf("wrap%0d_pc", k), 16'(dec1.out_pc), 16'(wp[k]));
                end
                k++;
            end
        end
        chk("wrap_count", 16'(k), 16'd3);

`ifdef IFETCH_PERF_EN
        dec0.out_ready = 1'b1;
        do_reset();
        chk("perf_reset", perf0, 16'd0);
        chk("perf_reset_w", perf1, 16'd0);
        for (int c = 0; c < 13; c++) tick();
        chk("perf_six", perf0, 16'd6);
        pc_load = 1'b1;
        pc_new  = 8'h00;
        tick();
        pc_load = 1'b0;
        chk("perf_flush_valid", 16'(dec0.out_valid), 16'd0);
        chk("perf_after_flush", perf0, 16'd6);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning prefetch FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 8'h00, meaning the first fetch address after reset.
REQ-003 SHALL have port CLK, input, width 1, meaning the single clock; all state updates on posedge.
REQ-004 SHALL have port RST, input, width 1, meaning the synchronous, active-low reset.
REQ-005 SHALL have port uniBus, inout, width 8, meaning the shared multiplexed address/data bus to Memory.
REQ-006 SHALL have port mem_req, output, width 1, meaning the address phase is valid this cycle.
REQ-007 SHALL have port mem_rd, output, width 1, meaning read (1) / write (0); always 1 from this block.
REQ-008 SHALL have port pc_load, input, width 1, meaning redirect the fetch stream this cycle.
REQ-009 SHALL have port pc_new, input, width 8, meaning the redirect target, sampled when pc_load=1.
REQ-010 SHALL have port out_valid, output, width 1, meaning out_byte/out_pc hold a fetched byte.
REQ-011 SHALL have port out_ready, input, width 1, meaning the decoder accepts the byte; transfer when valid&&ready.
REQ-012 SHALL have port out_byte, output, width 8, meaning the fetched instruction byte at the FIFO head.
REQ-013 SHALL have port out_pc, output, width 8, meaning the address out_byte was fetched from.

Function
REQ-014 SHALL implement FSM states IDLE, ADDR and DATA; IDLE->ADDR when FIFO occupancy < DEPTH; ADDR->DATA unconditionally; DATA->ADDR if room remains after this capture, else IDLE.
REQ-015 SHALL, in ADDR, drive uniBus=fetch_pc with mem_req=1, mem_rd=1; in all other states uniBus SHALL be 8'hzz and mem_req=0.
REQ-016 SHALL, in DATA, capture uniBus at the clock edge ending the cycle and push {byte, fetch_pc} into the FIFO, then increment fetch_pc.
REQ-017 SHALL have throughput of one byte per 2 cycles and latency of 3 cycles from entering ADDR to out_valid=1 with an empty FIFO.
REQ-018 SHALL wrap fetch_pc modulo 256 (8'hFF -> 8'h00) without any stall.
REQ-019 SHALL count the in-flight byte against capacity, so no push ever occurs while full.
REQ-020 SHALL allow a push and a pop in the same cycle, leaving occupancy unchanged.
REQ-021 SHALL make out_valid=0 exactly when the FIFO is empty, and hold out_byte/out_pc stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on pc_load=1, flush the FIFO and set fetch_pc=pc_new at that edge, with out_valid=0 on the next cycle.
REQ-023 SHALL complete an already-started transaction (pc_load during ADDR or DATA), discard its data, and start the first ADDR at pc_new immediately afterwards.
REQ-024 SHALL give pc_load priority over a simultaneous push or pop.

Reset
REQ-025 SHALL, while RST=0 at a clock edge, set state=IDLE, fetch_pc=RESET_PC, FIFO empty, discard flag=0, out_valid=0, mem_req=0, mem_rd=1, uniBus=8'hzz, out_byte=8'h00, out_pc=8'h00.
REQ-026 SHALL abandon any transaction on reset mid-operation, drive no bus in the following cycle, and issue its first ADDR one cycle after RST rises.

Configuration
REQ-027 SHALL, with IFETCH_PERF_EN defined, add output perf_cnt[15:0]; perf_cnt counts bytes pushed into the FIFO, saturates at 16'hFFFF, and clears on reset but not on pc_load.
REQ-028 SHALL, without IFETCH_PERF_EN, have no perf_cnt port and no counter logic, with all other behaviour unchanged.

Structure
REQ-029 SHALL take the FSM state enum (IDLE, ADDR, DATA) and the FIFO entry struct {byte, pc} from shared package ay8_pkg.
REQ-030 SHALL place the prefetch storage in sub-module ifetch_fifo (parameterised DEPTH, flush input, push/pop, count output).

Verification
REQ-031 SHALL check reset fetch: mem[0..3]=10,11,12,13, out_ready=1 -> out_byte 10,11,12,13 with out_pc 0..3, one byte per 2 cycles.
REQ-032 SHALL check backpressure: out_ready=0 with DEPTH=4 -> exactly 4 ADDR phases, then IDLE, mem_req=0, out_byte=10 held; out_ready=1 -> fetching resumes at pc 4.
REQ-033 SHALL check redirect: pc_load=1 with pc_new=8'h02 during DATA of pc 0 -> pc 0 byte discarded, next bytes 12,13 with out_pc 2,3.
REQ-034 SHALL check wrap: RESET_PC=8'hFE with mem[FE]=AA, mem[FF]=BB, mem[0]=10 -> out_pc FE,FF,00 and bytes AA,BB,10.
REQ-035 SHALL check reset mid-DATA: RST=0 for one cycle -> out_valid=0 and uniBus=zz next cycle, then fetch restarts at RESET_PC.
REQ-036 SHALL check the macro: with IFETCH_PERF_EN, 6 bytes pushed and 1 flush -> perf_cnt=6.
